// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
//   fetch_entry_t : one queued fetch {pc, instr} at the default widths
//   pc_inc        : wide PC increment; callers truncate to their own ADDR_W
package if_pkg;

  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_DATA_W   = 32;
  localparam int unsigned IF_FQ_DEPTH = 2;
  localparam int unsigned FQ_PTR_W    = $clog2(IF_FQ_DEPTH);
  localparam int unsigned PC_MAX_W    = 64;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Truncating the result to ADDR_W gives the mod 2^ADDR_W wrap.
  function automatic logic [PC_MAX_W-1:0] pc_inc(input logic [PC_MAX_W-1:0] pc,
                                                 input logic [PC_MAX_W-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries.
//   flush     : empties the queue; wins over push and pop
//   push/pop  : may coincide; pop on empty and push on full without pop are ignored
//   head      : entry at the read pointer (meaningful only when !empty)
//   count/empty/full : occupancy
module fetch_queue
  import if_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = IF_FQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  entry_t               push_data,
  input  logic                 pop,
  output entry_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed when the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, queues the returned words and hands them to ID.
//   clk, rst_n                  : clock, async active-low reset
//   imem_req/imem_addr          : read request and address (address = PC)
//   imem_rdata                  : read data, valid the cycle after imem_req
//   redirect_valid/redirect_pc  : branch/jump redirect, squashes everything in flight
//   id_valid/id_ready           : handshake to ID
//   id_instr/id_pc/id_pc_next   : queue head and its sequential successor PC
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1,
  parameter int unsigned       FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_next
);

  localparam int unsigned CNT_W  = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned USED_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic [USED_W-1:0] used;
  logic [ADDR_W-1:0] pc_seq;
  entry_t            push_data;
  entry_t            head;
  logic [CNT_W-1:0]  fq_count;
  logic              fq_empty;
  logic              fq_full;

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fq_count),
    .empty     (fq_empty),
    .full      (fq_full)
  );

  // Credit check: queued + in-flight entries, less the one leaving now, must leave a free slot.
  assign pop    = id_valid && id_ready;
  assign used   = USED_W'(fq_count) + USED_W'(inflight_q) - USED_W'(pop);
  // The full guard never binds under the credit rule; it keeps a full queue from being overrun.
  assign issue  = rst_n && !redirect_valid && !(fq_full && !pop)
                  && (used < USED_W'(FQ_DEPTH));
  assign pc_seq = ADDR_W'(pc_inc(PC_MAX_W'(pc_q), PC_MAX_W'(PC_INC)));

  // Response of last cycle's issue is dropped if a redirect lands on it.
  assign push            = inflight_q && !redirect_valid;
  assign push_data.pc    = inflight_pc_q;
  assign push_data.instr = imem_rdata;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // Head fields read as zero while the queue is empty.
  assign id_valid   = !fq_empty && !redirect_valid;
  assign id_instr   = fq_empty ? '0 : head.instr;
  assign id_pc      = fq_empty ? '0 : head.pc;
  assign id_pc_next = fq_empty ? '0
                    : ADDR_W'(pc_inc(PC_MAX_W'(head.pc), PC_MAX_W'(PC_INC)));

  // PC and in-flight tracking; redirect overrides sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (redirect_valid) pc_q <= redirect_pc;
      else if (issue)     pc_q <= pc_seq;
    end
  end

endmodule
